// File: rtl/pb_conditioner.sv
// Push-button front end: two-FF synchroniser, sample-tick debouncer and one-clock press/release pulses.
// Define PB_LONG_PRESS_EN to build the short/long press classifier (hold counter + 3-state FSM).
module pb_conditioner #(
    parameter int SAMPLE_DIV = 400000,
    parameter int DEB_DEPTH  = 4,
    parameter int LONG_TICKS = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_in,
    output logic pb_debounced,
    output logic pb_1pulse,
    output logic pb_release_pulse,
    output logic pb_long,
    output logic sample_tick
);

    localparam int PRESC_W = $clog2(SAMPLE_DIV);

    if (SAMPLE_DIV < 2 || DEB_DEPTH < 2 || LONG_TICKS < 1) begin : g_param_check
        $error("pb_conditioner: SAMPLE_DIV>=2, DEB_DEPTH>=2, LONG_TICKS>=1 required");
    end

    logic                 sync1_q, sync2_q;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [DEB_DEPTH-1:0] shift_q, shift_d;
    logic                 deb_q, deb_d;
    logic                 prev_q;
    logic                 rel_q;
    logic                 onep_q;
    logic                 rise, fall;

    assign sample_tick = (presc_q == PRESC_W'(SAMPLE_DIV - 1));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        presc_d = sample_tick ? '0 : presc_q + PRESC_W'(1);
        shift_d = sample_tick ? {shift_q[DEB_DEPTH-2:0], sync2_q} : shift_q;
        deb_d   = deb_q;
        if (&shift_q) begin
            deb_d = 1'b1;
        end else if (~|shift_q) begin
            deb_d = 1'b0;
        end
    end

    assign rise = deb_q & ~prev_q;
    assign fall = ~deb_q & prev_q;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            presc_q <= '0;
            shift_q <= '0;
            deb_q   <= 1'b0;
            prev_q  <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync1_q <= pb_in;
            sync2_q <= sync1_q;
            presc_q <= presc_d;
            shift_q <= shift_d;
            deb_q   <= deb_d;
            prev_q  <= deb_q;
            rel_q   <= fall;
        end
    end

`ifdef PB_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_TICKS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_LONG
    } state_e;

    state_e            state_q;
    logic [HOLD_W-1:0] hold_q;
    logic              long_q;
    logic              hold_at_max;

    assign hold_at_max = (hold_q == HOLD_W'(LONG_TICKS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            onep_q  <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            if (rise) begin
                hold_q <= '0;
            end else if (sample_tick && deb_q && !hold_at_max) begin
                hold_q <= hold_q + HOLD_W'(1);
            end

            onep_q <= 1'b0;
            long_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (rise) state_q <= ST_PRESSED;
                end
                // Reaching the threshold wins over a coincident fall: that press is long.
                ST_PRESSED: begin
                    if (hold_at_max) begin
                        long_q  <= 1'b1;
                        state_q <= fall ? ST_IDLE : ST_LONG;
                    end else if (fall) begin
                        onep_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_LONG: begin
                    if (fall) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pb_long = long_q;
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            onep_q <= 1'b0;
        end else begin
            onep_q <= rise;
        end
    end

    assign pb_long = 1'b0;
`endif

    assign pb_debounced     = deb_q;
    assign pb_1pulse        = onep_q;
    assign pb_release_pulse = rel_q;

endmodule
